// File: rtl/rr_arb16_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
// Holds requester count, index/counter widths and FSM encodings.
package rr_arb16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb16_onehotdec.sv
// One-hot to binary index decoder.
// Output is zero when the input vector is all-zero.
module onehotdec #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    // OR together the indices of all set bits; exact for one-hot input
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = idx | W'(i);
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with hold-time limit.
// Registered one-hot grant; preempt pulses on hold timeout.
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             preempt
);

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] hold, hold_n;
    logic             preempt_n;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W-1:0]   win;
    logic               owner;
    logic               timeout;

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        win = ptr + off;
    end

    assign owner   = |(req & gnt);
    assign timeout = (hold == CNT_W'(MAX_HOLD - 1));

    // Next-state, grant, pointer, hold counter and preempt decisions
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        ptr_n     = ptr;
        hold_n    = hold;
        preempt_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    gnt_n      = '0;
                    gnt_n[win] = 1'b1;
                    ptr_n      = win + IDX_W'(1);
                    hold_n     = '0;
                    state_n    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (rel || !owner || timeout) begin
                    gnt_n     = '0;
                    hold_n    = '0;
                    state_n   = S_IDLE;
                    preempt_n = timeout && !rel && owner;
                end else begin
                    hold_n = hold + CNT_W'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                hold_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            ptr     <= '0;
            hold    <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            ptr     <= ptr_n;
            hold    <= hold_n;
            preempt <= preempt_n;
        end
    end

    onehotdec #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_dec (
        .onehot (gnt),
        .idx    (gnt_idx)
    );

    assign busy = |gnt;

endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16 (MAX_HOLD = 8).
// Expected outputs are queued at drive time and popped after the edge.
module tb_rr_arb16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        busy;
    logic        preempt;

    typedef struct {
        logic [15:0] g;
        logic [3:0]  idx;
        logic        b;
        logic        p;
        string       tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    rr_arb16 #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.tag, ".gnt"}, gnt, e.g);
        check({e.tag, ".idx"}, 16'(gnt_idx), 16'(e.idx));
        check({e.tag, ".busy"}, 16'(busy), 16'(e.b));
        check({e.tag, ".pre"}, 16'(preempt), 16'(e.p));
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs
    task automatic step(input string tag, input logic [15:0] r,
                        input logic l, input logic v,
                        input int i, input logic p);
        exp_t e;
        req   = r;
        rel   = l;
        e.g   = '0;
        if (v) e.g[i] = 1'b1;
        e.idx = v ? 4'(i) : 4'd0;
        e.b   = v;
        e.p   = p;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_all(q.pop_front());
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        exp_t z;
        z.g = '0; z.idx = '0; z.b = 1'b0; z.p = 1'b0; z.tag = "reset";
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        #2;
        check_all(z);
        repeat (2) @(posedge clk);
        #1;
        check_all(z);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, release after 3 cycles, ptr becomes 1
        step("r26_g", 16'h0001, 0, 1, 0, 0);
        step("r26_h1", 16'h0001, 0, 1, 0, 0);
        step("r26_h2", 16'h0001, 0, 1, 0, 0);
        step("r26_rel", 16'h0001, 1, 0, 0, 0);
        step("r26_ptr", 16'h0003, 0, 1, 1, 0);
        step("r26_rel2", 16'h0003, 1, 0, 0, 0);
        step("idle_rel", 16'h0000, 1, 0, 0, 0);

        // All requesting: order 0..15,0 with idle cycle between
        pulse_rst();
        for (int k = 0; k < 17; k++) begin
            step($sformatf("r27_g%0d", k), 16'hFFFF, 0, 1, k % 16, 0);
            step($sformatf("r27_r%0d", k), 16'hFFFF, 1, 0, 0, 0);
        end

        // Wrap: move ptr to 15 via grant to 14, then 15 then 0
        step("r28_p14", 16'h4000, 0, 1, 14, 0);
        step("r28_r14", 16'h4000, 1, 0, 0, 0);
        step("r28_g15", 16'h8001, 0, 1, 15, 0);
        step("r28_r15", 16'h8001, 1, 0, 0, 0);
        step("r28_g0", 16'h8001, 0, 1, 0, 0);
        step("r28_r0", 16'h8001, 1, 0, 0, 0);

        // Hold timeout: 8 grant cycles then preempt pulse
        step("r29_g", 16'h0010, 0, 1, 4, 0);
        for (int k = 1; k < 8; k++)
            step($sformatf("r29_h%0d", k), 16'h0010, 0, 1, 4, 0);
        step("r29_to", 16'h0010, 0, 0, 0, 1);
        step("r29_reg", 16'h0010, 0, 1, 4, 0);
        step("r29_rel", 16'h0010, 1, 0, 0, 0);

        // Release coinciding with timeout: no preempt
        step("to_rel_g", 16'h0010, 0, 1, 4, 0);
        for (int k = 1; k < 8; k++)
            step($sformatf("to_rel_h%0d", k), 16'h0010, 0, 1, 4, 0);
        step("to_rel_x", 16'h0010, 1, 0, 0, 0);
        step("to_rel_i", 16'h0000, 0, 0, 0, 0);

        // Owner 3 drops request while 5 waits
        step("r30_g3", 16'h0008, 0, 1, 3, 0);
        step("r30_oth", 16'h0028, 0, 1, 3, 0);
        step("r30_drop", 16'h0020, 0, 0, 0, 0);
        step("r30_g5", 16'h0020, 0, 1, 5, 0);
        step("r30_rel", 16'h0020, 1, 0, 0, 0);

        // Reset mid-BUSY between edges, then search restarts at 0
        step("r31_g0", 16'h0001, 0, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        z.tag = "r31_async";
        check_all(z);
        @(negedge clk);
        rst = 1'b0;
        step("r31_g0b", 16'h0005, 0, 1, 0, 0);
        step("r31_rel", 16'h0005, 1, 0, 0, 0);
        step("r31_g2", 16'h0004, 0, 1, 2, 0);
        step("r31_rel2", 16'h0004, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 The block SHALL expose parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester may hold a grant (range 1..255).
REQ-002 The block SHALL expose port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL expose port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL expose port req, input, 16, per-requester request; bit i = requester i.
REQ-005 The block SHALL expose port rel, input, 1, release strobe from the current owner.
REQ-006 The block SHALL expose port gnt, output, 16, registered one-hot grant; all-zero when idle.
REQ-007 The block SHALL expose port gnt_idx, output, 4, binary index of the set gnt bit; 0 when gnt is all-zero.
REQ-008 The block SHALL expose port busy, output, 1, high while any grant is held.
REQ-009 The block SHALL expose port preempt, output, 1, one-cycle pulse when a grant is revoked by hold timeout.

Function
REQ-010 The controller SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 In IDLE with req != 0, the controller SHALL select the first set req bit searching upward, cyclically, from pointer ptr (4 bits), load gnt with that bit, and enter BUSY on the same edge.
REQ-012 Grant latency SHALL be exactly one clock: req sampled at edge n gives gnt valid after edge n.
REQ-013 On each grant, ptr SHALL load winner index + 1 modulo 16 (winner 15 wraps ptr to 0).
REQ-014 In IDLE with req == 0, gnt, ptr and hold counter SHALL stay unchanged or zero as in REQ-020.
REQ-015 In BUSY, the hold counter (8 bits) SHALL increment every cycle starting from 0 on the grant edge.
REQ-016 BUSY SHALL exit to IDLE, clearing gnt, on the first edge where rel = 1, or req[gnt_idx] = 0, or hold counter = MAX_HOLD-1.
REQ-017 When exit is caused solely by hold timeout, preempt SHALL pulse high for exactly the cycle after that edge; it SHALL stay low when rel or request drop coincides with timeout.
REQ-018 After any exit, gnt SHALL be all-zero for at least one full cycle before the next grant (no back-to-back grant switch).
REQ-019 rel asserted in IDLE SHALL be ignored; req changes of non-owners during BUSY SHALL not affect gnt.
REQ-020 gnt_idx SHALL be derived combinationally from registered gnt; busy SHALL equal OR-reduction of gnt.

Reset
REQ-021 On rst high, asynchronously: state = IDLE, gnt = 0, gnt_idx = 0, busy = 0, preempt = 0, ptr = 0, hold counter = 0.
REQ-022 Reset asserted during BUSY SHALL drop the grant immediately without a preempt pulse; first grant after release SHALL use ptr = 0.

Structure
REQ-023 Requester count (16), index width (4), counter width (8) and state encodings SHALL live in the shared project constants header/package.
REQ-024 gnt_idx SHALL be produced by instantiating the existing onehotdec sub-module on gnt; no duplicate decode logic.
REQ-025 The cyclic priority search SHALL be a single combinational block (double-width masked priority or rotate-and-search), no extra pipeline stage.

Verification
REQ-026 Reset then req=16'h0001 held, rel pulse after 3 cycles -> gnt=16'h0001, gnt_idx=0, busy=1 one cycle after req; gnt=0 after rel; ptr=1.
REQ-027 req=16'hFFFF held, rel each grant -> grant order 0,1,2,...,15,0 with one idle cycle between grants; gnt_idx matches each.
REQ-028 req=16'h8001, ptr=15 -> grant to 15, then (after release) to 0 (wrap).
REQ-029 MAX_HOLD=8, req=16'h0010 held, rel=0 -> gnt=16'h0010 for exactly 8 cycles, then gnt=0 and preempt=1 for one cycle.
REQ-030 Owner 3 drops req[3] mid-grant while req[5]=1 -> gnt clears next edge, preempt=0, next grant 16'h0020 one cycle later.
REQ-031 rst asserted mid-BUSY between clock edges -> gnt=0, busy=0 immediately; after release req=16'h0004 granted with ptr search from 0.
